// File: rtl/decimator_nchan_accum.sv
// decimator_nchan_accum: runtime-programmable whole-factor decimator.
// It emits one output for every F accepted samples. In drop mode the output
// is the first sample of the group. In accumulate mode it is the group sum.
// The factor and mode are sampled only at a group start, so a change in the
// middle of a group applies to the next group.
module decimator_nchan_accum #(
    parameter int DATA_WIDTH   = 16,
    parameter int FACTOR_WIDTH = 8,
    parameter int SIGNED       = 1,
    parameter int OUT_WIDTH    = DATA_WIDTH + FACTOR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sync,
    input  logic [FACTOR_WIDTH-1:0] factor,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    output logic [OUT_WIDTH-1:0]    data_out
);

    localparam logic [FACTOR_WIDTH-1:0] ONE = {{(FACTOR_WIDTH-1){1'b0}}, 1'b1};

    logic [FACTOR_WIDTH-1:0] count_q, count_d;
    logic [OUT_WIDTH-1:0]    acc_q, acc_d;
    logic [FACTOR_WIDTH-1:0] f_lat_q, f_lat_d;
    logic                    mode_lat_q, mode_lat_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]    data_out_q, data_out_d;

    logic [OUT_WIDTH-1:0]    sample_ext;
    logic                    accept;
    logic                    start;
    logic                    last;
    logic [FACTOR_WIDTH-1:0] count_base;
    logic [FACTOR_WIDTH-1:0] factor_eff;
    logic [FACTOR_WIDTH-1:0] f_use;

    // Widen the sample to the accumulator width. Signed samples are
    // sign-extended and unsigned samples are zero-extended.
    generate
        if (SIGNED != 0) begin : g_sext
            assign sample_ext = {{(OUT_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        end else begin : g_zext
            assign sample_ext = {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, data_in};
        end
    endgenerate

    // Decode the group phase. A sync makes the current sample behave as if
    // the count were already zero.
    always_comb begin
        accept     = en & in_valid;
        count_base = sync ? '0 : count_q;
        start      = accept & (count_base == '0);
        factor_eff = (factor == '0) ? ONE : factor;
        f_use      = start ? factor_eff : f_lat_q;
        last       = accept & (count_base == (f_use - ONE));
    end

    // Compute the next state for the counter, the accumulator/drop register,
    // the latches and the output.
    always_comb begin
        count_d     = count_q;
        acc_d       = acc_q;
        f_lat_d     = f_lat_q;
        mode_lat_d  = mode_lat_q;
        out_valid_d = 1'b0;
        data_out_d  = data_out_q;
        if (en) begin
            if (sync) begin
                count_d = '0;
                acc_d   = '0;
            end
            if (accept) begin
                if (start) begin
                    f_lat_d    = factor_eff;
                    mode_lat_d = mode;
                    acc_d      = sample_ext;
                end else if (mode_lat_q) begin
                    acc_d = acc_q + sample_ext;
                end
                // In drop mode acc_d still holds the first sample of the
                // group, so the same register serves both modes.
                if (last) begin
                    count_d     = '0;
                    out_valid_d = 1'b1;
                    data_out_d  = acc_d;
                end else begin
                    count_d = count_base + ONE;
                end
            end
        end
    end

    // State registers. An asynchronous reset discards any partial group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            acc_q       <= '0;
            f_lat_q     <= ONE;
            mode_lat_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            f_lat_q     <= f_lat_d;
            mode_lat_q  <= mode_lat_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_decimator_nchan_accum.sv
// Bench for decimator_nchan_accum. A group-level reference model runs
// inside the stimulus task and queues the expected output value and the
// cycle it should appear in. A separate monitor checks every output pulse
// against that queue.
module tb_decimator_nchan_accum;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int OW = DW + FW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          sync = 1'b0;
    logic [FW-1:0] factor = '0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_valid;
    logic [OW-1:0] data_out;

    decimator_nchan_accum #(
        .DATA_WIDTH  (DW),
        .FACTOR_WIDTH(FW),
        .SIGNED      (1),
        .OUT_WIDTH   (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .factor   (factor),
        .mode     (mode),
        .in_valid (in_valid),
        .data_in  (data_in),
        .out_valid(out_valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference model state: the number of samples in the current group,
    // the latched factor and mode, the running sum and the first sample.
    int   m_n = 0;
    int   m_f = 1;
    int   m_mode = 0;
    int   m_sum = 0;
    int   m_first = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every output pulse must match the oldest queued expectation,
    // both in value and in the cycle it appears.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_pulse: unexpected out_valid at cycle %0d data_out=%0h, required no output", cyc, data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_out !== e.val || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_pulse: got data_out=%0h at cycle %0d, required %0h at cycle %0d", data_out, cyc, e.val, e.cyc);
                end else begin
                    $display("[TB] out data_out=%0h cycle=%0d ok", data_out, cyc);
                end
            end
        end
    end

    // Apply one cycle of stimulus and advance the reference model.
    task automatic step(input logic e, input logic s, input logic v,
                        input logic [DW-1:0] d, input logic [FW-1:0] f, input logic m);
        int sd;
        exp_t ex;
        @(negedge clk);
        en = e; sync = s; in_valid = v; data_in = d; factor = f; mode = m;
        sd = int'($signed(d));
        if (e) begin
            if (s) m_n = 0;
            if (v) begin
                if (m_n == 0) begin
                    m_f     = (f == 0) ? 1 : int'(f);
                    m_mode  = int'(m);
                    m_sum   = 0;
                    m_first = sd;
                end
                m_sum += sd;
                m_n++;
                if (m_n == m_f) begin
                    ex.val = (m_mode != 0) ? OW'(m_sum) : OW'(m_first);
                    ex.cyc = cyc + 1;
                    exp_q.push_back(ex);
                    m_n = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, factor, mode);
    endtask

    task automatic check_zero_outputs(input string name);
        n_tests++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL %s: out_valid=%b data_out=%0h, required 0/0", name, out_valid, data_out);
        end else begin
            $display("[TB] %s outputs zero ok", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0; sync = 1'b0; in_valid = 1'b0;
        #1;
        check_zero_outputs("reset_async");
        m_n = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state check
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_state");
        rst = 1'b1;
        idle(2);

        // F=4 drop mode, ramp 0..15, continuous valid -> 0,4,8,12
        for (int i = 0; i < 16; i++) step(1, 0, 1, DW'(i), 8'd4, 1'b0);
        idle(2);
        // F=4 accumulate mode, ramp -> 6,22,38,54
        for (int i = 0; i < 16; i++) step(1, 0, 1, DW'(i), 8'd4, 1'b1);
        idle(2);
        // Same ramp with valid toggling every cycle
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, DW'(i), 8'd4, 1'b1);
            step(1, 0, 0, 16'hdead, 8'd4, 1'b1);
        end
        idle(2);

        // F=255: 255 x -128 -> -32640, then 255 x 127 -> 32385
        for (int i = 0; i < 255; i++) step(1, 0, 1, 16'hff80, 8'd255, 1'b1);
        for (int i = 0; i < 255; i++) step(1, 0, 1, 16'd127, 8'd255, 1'b1);
        idle(2);

        // F=0 (treated as 1) then F=1: 5, -3, 7 -> three back-to-back pulses
        step(1, 0, 1, 16'd5, 8'd0, 1'b1);
        step(1, 0, 1, 16'hfffd, 8'd1, 1'b1);
        step(1, 0, 1, 16'd7, 8'd1, 1'b1);
        idle(2);

        // Factor changes from 4 to 2 after sample 1 of a group
        for (int i = 0; i < 2; i++) step(1, 0, 1, DW'(10 + i), 8'd4, 1'b1);
        for (int i = 0; i < 6; i++) step(1, 0, 1, DW'(20 + i), 8'd2, 1'b1);
        idle(2);

        // sync after 2 of 4 samples: partial group discarded
        step(1, 0, 1, 16'd100, 8'd4, 1'b1);
        step(1, 0, 1, 16'd200, 8'd4, 1'b1);
        step(1, 1, 0, 16'd0, 8'd4, 1'b1);
        for (int i = 0; i < 4; i++) step(1, 0, 1, DW'(i + 1), 8'd4, 1'b1);
        // sync on what would be the last-sample cycle: that sample restarts
        step(1, 0, 1, 16'd9, 8'd4, 1'b1);
        step(1, 0, 1, 16'd9, 8'd4, 1'b1);
        step(1, 0, 1, 16'd9, 8'd4, 1'b1);
        step(1, 1, 1, 16'd3, 8'd4, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 16'd4, 8'd4, 1'b1);
        idle(2);

        // Reset in the middle of a group
        step(1, 0, 1, 16'd50, 8'd4, 1'b1);
        step(1, 0, 1, 16'd60, 8'd4, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 1, DW'(i + 7), 8'd4, 1'b1);
        idle(2);

        // en low for 3 cycles in the middle of a group
        step(1, 0, 1, 16'd1, 8'd4, 1'b1);
        step(1, 0, 1, 16'd2, 8'd4, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h7777, 8'd9, 1'b0);
        step(1, 0, 1, 16'd3, 8'd4, 1'b1);
        step(1, 0, 1, 16'd4, 8'd4, 1'b1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic e, s, v, m;
            logic [FW-1:0] f;
            logic [DW-1:0] d;
            e = ($urandom_range(0, 9) != 0);
            s = e && ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            m = 1'($urandom_range(0, 1));
            f = FW'($urandom_range(0, 6));
            d = DW'($urandom);
            step(e, s, v, d, f, m);
        end
        idle(4);

        // Every expected output must have been seen
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decimator_nchan_accum.md
Name: decimator_nchan_accum

Overview:
Runtime-programmable decimator that generalises the fixed whole-factor decimator. It accepts a valid-qualified sample stream and emits one output per group of F accepted samples. Two modes: drop (keep the first sample of each group) and accumulate-and-dump (the sum of the F samples). It sits between a sample source (ADC or filter output) and downstream DSP blocks that run at the reduced rate.

Parameters:
DATA_WIDTH, 16, input sample width.
FACTOR_WIDTH, 8, width of the factor port; legal factors are 1..2^FACTOR_WIDTH-1.
SIGNED, 1, 1 = two's-complement samples (sign-extend), 0 = unsigned (zero-extend).
OUT_WIDTH, DATA_WIDTH+FACTOR_WIDTH, output width; must not be set below DATA_WIDTH+FACTOR_WIDTH.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  global enable; when low, state is frozen and inputs are ignored.
sync  input  1  restarts group phase; counter and accumulator cleared.
factor  input  FACTOR_WIDTH  decimation factor F; 0 is treated as 1.
mode  input  1  0 = drop, 1 = accumulate-and-dump.
in_valid  input  1  data_in is valid this cycle.
data_in  input  DATA_WIDTH  input sample.
out_valid  output  1  one-cycle pulse; data_out is valid.
data_out  output  OUT_WIDTH  decimated sample (extended) or group sum.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, data_out=0, count=0, acc=0, f_lat=1, mode_lat=0.
- Accepted sample: en=1 and in_valid=1. No backpressure; every accepted sample is consumed.
- Group start occurs when count==0 and a sample is accepted.
  - factor is latched into f_lat (0 maps to 1) and mode into mode_lat.
  - Changes to factor or mode mid-group take effect at the next group start only.
- Counter: count increments on each accepted sample. When count==f_lat-1, it wraps to 0.
- Accumulator, mode_lat=1:
  - At group start, acc = ext(data_in).
  - Otherwise acc = acc + ext(data_in) at OUT_WIDTH.
  - ext() sign- or zero-extends per SIGNED.
  - Overflow is impossible by the width rule.
- Drop register, mode_lat=0: captures ext(data_in) at group start and ignores the remaining samples of the group.
- Output:
  - On the cycle the last sample of the group is accepted (count==f_lat-1), the next clock edge sets out_valid=1 and data_out to the sum (mode 1) or the held first sample (mode 0).
  - Latency is 1 cycle after the last sample.
  - out_valid is high for exactly one cycle.
  - data_out holds its value until the next output.
- F=1: every accepted sample produces an output 1 cycle later, so out_valid can be high on consecutive cycles.
- Back-to-back groups: the last sample of group k and the first sample of group k+1 on adjacent cycles need no bubble. The accumulator restarts directly from data_in.
- en=0: count, acc and latches hold; out_valid=0 on the following edge. A pending output is not lost, because output registration is triggered only by acceptance.
- sync=1 (requires en=1):
  - count and acc are cleared, and any partial group is discarded with no output.
  - If in_valid=1 in the same cycle, that sample is treated as the group start, and factor/mode are latched.
  - sync has priority over group completion: a sync arriving on the last-sample cycle suppresses that output.
- Reset mid-operation: partial group discarded, all outputs 0 immediately; the first sample after release is a group start.
- Gaps in in_valid do not affect phase; only accepted samples count.

Test Plan:
- DATA_WIDTH=16, F=4, mode=0, ramp 0..15 with in_valid continuous -> out_valid pulses 1 cycle after samples 3, 7, 11, 15 with data_out 0, 4, 8, 12.
- F=4, mode=1, same ramp -> data_out 6, 22, 38, 54. Then repeat with in_valid toggling 1/0 each cycle -> same values, and each pulse arrives 1 cycle after sample 3/7/11/15 is accepted.
- SIGNED=1, DATA_WIDTH=8, F=255, mode=1, 255 samples of -128 -> single output -32640 (16-bit 0x8080). Then 255 samples of 127 -> 32385.
- F=0 then F=1, mode=1, samples 5, -3, 7 -> three consecutive out_valid pulses with data_out 5, -3, 7 (sign-extended).
- F=4, change factor to 2 after sample 1 of a group -> current group still completes at 4 samples; subsequent groups use 2.
- Interrupts: sync after 2 of 4 samples -> no output, and the next 4 samples sum correctly. rst low mid-group -> out_valid and data_out go to 0 immediately. en low for 3 cycles mid-group -> sum unchanged, and the output is delayed by 3 cycles.
